hht_fetch_sched: RTL
====================

Name: hht_fetch_sched

Overview:
- Sequences operand fetch for the HHT control datapath: two read streams share one single-ported read memory.
- Channel 0 is the matrix column stream (e.g. base 340, 205 words). Channel 1 is the v-value stream (e.g. base 2, 32 words).
- Each channel is loaded with base/length, issued reads are round-robin arbitrated, and returned words are steered back with a per-channel valid.
- Sits between the HHT control FSM (start/done) and the shared operand memory.

Parameters:
- AW, 32, memory address width.
- DW, 32, memory data width.
- LEN_W, 16, burst-length counter width.

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; latches base0/len0/base1/len1
- base0  in  AW  column-stream start address
- len0  in  LEN_W  column-stream word count
- base1  in  AW  v-stream start address
- len1  in  LEN_W  v-stream word count
- rdy0  in  1  channel-0 consumer throttle
- rdy1  in  1  channel-1 consumer throttle
- mem_addr  out  AW  read address (registered)
- mem_rd  out  1  read strobe (registered)
- mem_rdata  in  DW  read data, valid the cycle after mem_rd
- dout  out  DW  returned word (registered)
- dout_vld0  out  1  dout belongs to channel 0
- dout_vld1  out  1  dout belongs to channel 1
- busy  out  1  high from the start edge until the done cycle inclusive
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (Rst=0 at an edge):
  - All outputs go to 0. State goes to IDLE, counters clear, rr pointer = 1 (so channel 0 wins first).
  - In-flight reads are discarded; no vld is asserted for them after reset.
  - Applies mid-operation too.
- States:
  - IDLE: on start, load addr0=base0, rem0=len0, addr1=base1, rem1=len1. Go to DONE if len0==0 && len1==0, else RUN. start is ignored in every other state.
  - RUN: each edge, elig_c = (rem_c!=0) && rdy_c.
    - If both eligible, grant the channel != rr pointer; if one eligible, grant it; if none, issue nothing (mem_rd=0).
    - On grant c: mem_addr<=addr_c, mem_rd<=1, addr_c<=addr_c+1 (mod 2^AW), rem_c<=rem_c-1, rr<=c, tag pipeline <= c.
    - When the issue makes rem0==0 && rem1==0, go to DRAIN.
  - DRAIN: mem_rd=0; wait until the last issued word has been returned (tag pipeline empty), then go to DONE.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Latency:
  - Grant at edge k: mem_addr/mem_rd visible in cycle k..k+1.
  - mem_rdata is captured at edge k+2 into dout, with dout_vld<c> high for that one cycle.
  - One word per cycle sustained; dout_vld0 and dout_vld1 are never both high.
- Throttle: rdy_c low blocks new grants to channel c only. Words already issued are still delivered; the consumer must sink every beat presented.
- A zero-length channel is never granted. The other channel streams at full rate.
- rdy toggling every cycle is legal; arbitration is re-evaluated each edge with no lost or duplicated addresses.
- Counter wrap: addr_c wraps at 2^AW silently. len=2^LEN_W-1 is supported.
- Simultaneous start and Rst=0: reset wins.

Decomposition:
- Shared package hht_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - Channel id constants CH_COL=0, CH_V=1.
  - Memory latency constant MEM_LAT=1.
- Sub-module hht_rr_arb2: two-requester round-robin arbiter. Inputs req[1:0] and last-grant pointer; outputs one-hot grant.
  - Combinational, with the pointer register held in the parent.

Test Plan:
- base0=340 len0=4, base1=2 len1=2, rdy0=rdy1=1, memory image as in the HHT benches.
  - mem_addr sequence 340,2,341,3,342,343.
  - dout beats (ch,data): (0,2),(1,71),(0,18),(1,79),(0,16),(0,28).
  - done 1 cycle after the last beat.
- Same config with rdy1=0 for the first 3 cycles: addresses 340,341,342, then 2,343,3; per-channel data order preserved.
- len0=205 base0=340, len1=32 base1=2, both rdy: exactly 205 dout_vld0 and 32 dout_vld1 beats; last ch0 word 18 (addr 544); busy spans start..done.
- len0=len1=0, then start: done pulses on the cycle after start; mem_rd never asserts.
- Rst=0 for 1 cycle mid-RUN, after 3 issues: all outputs 0 next cycle, no further vld. A new start with base0=340 len0=1 returns (0,2) cleanly.
- start pulsed during RUN with different bases: ignored; the original address sequence completes unchanged.

Source files
------------

// File: rtl/hht_pkg.sv
// Shared types and constants for the HHT operand-fetch scheduler.
// Channel ids double as indices into the per-channel register arrays.
package hht_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam logic CH_COL = 1'b0;
  localparam logic CH_V   = 1'b1;

  // Cycles from the registered read strobe to valid read data.
  localparam int MEM_LAT = 1;

  // Tag pipeline depth: one stage for the strobe register plus the memory latency.
  localparam int TAG_DEPTH = MEM_LAT + 1;

endpackage

// File: rtl/hht_rr_arb2.sv
// Two-requester round-robin arbiter.
// The last-grant pointer is a register kept in the parent module.
module hht_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // On contention, the channel that did not win last time gets the grant.
  // Otherwise the request vector is already one-hot or empty.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/hht_fetch_sched.sv
// Two-stream operand fetch scheduler sharing one single-ported read memory.
// Reads are round-robin arbitrated; each returned word is tagged with its channel.
module hht_fetch_sched
  import hht_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [AW-1:0]    base0_i,
  input  logic [LEN_W-1:0] len0_i,
  input  logic [AW-1:0]    base1_i,
  input  logic [LEN_W-1:0] len1_i,
  input  logic             rdy0_i,
  input  logic             rdy1_i,
  output logic [AW-1:0]    mem_addr_o,
  output logic             mem_rd_o,
  input  logic [DW-1:0]    mem_rdata_i,
  output logic [DW-1:0]    dout_o,
  output logic             dout_vld0_o,
  output logic             dout_vld1_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e                    state_q;
  logic [1:0][AW-1:0]        addr_q;
  logic [1:0][AW-1:0]        addr_d;
  logic [1:0][LEN_W-1:0]     rem_q;
  logic [1:0][LEN_W-1:0]     rem_d;
  logic                      rr_q;
  logic [TAG_DEPTH-1:0]      tag_vld_q;
  logic [TAG_DEPTH-1:0]      tag_ch_q;

  logic [1:0]                rdy;
  logic [1:0]                elig;
  logic [1:0]                gnt;
  logic                      issue;
  logic                      gnt_ch;
  logic                      last_issue;

  assign rdy = {rdy1_i, rdy0_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    assign elig[gi]   = (state_q == RUN) && (rem_q[gi] != '0) && rdy[gi];
    assign addr_d[gi] = gnt[gi] ? addr_q[gi] + AW'(1) : addr_q[gi];
    assign rem_d[gi]  = gnt[gi] ? rem_q[gi] - LEN_W'(1) : rem_q[gi];
  end

  hht_rr_arb2 u_arb (
    .req_i  (elig),
    .last_i (rr_q),
    .gnt_o  (gnt)
  );

  assign issue      = |gnt;
  assign gnt_ch     = gnt[CH_V];
  assign last_issue = issue && (rem_d[CH_COL] == '0) && (rem_d[CH_V] == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      rr_q        <= CH_V;
      tag_vld_q   <= '0;
      tag_ch_q    <= '0;
      mem_addr_o  <= '0;
      mem_rd_o    <= 1'b0;
      dout_o      <= '0;
      dout_vld0_o <= 1'b0;
      dout_vld1_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      // Return path runs every cycle so words issued just before DRAIN still land.
      tag_vld_q   <= {tag_vld_q[TAG_DEPTH-2:0], issue};
      tag_ch_q    <= {tag_ch_q[TAG_DEPTH-2:0], gnt_ch};
      dout_vld0_o <= tag_vld_q[TAG_DEPTH-1] && (tag_ch_q[TAG_DEPTH-1] == CH_COL);
      dout_vld1_o <= tag_vld_q[TAG_DEPTH-1] && (tag_ch_q[TAG_DEPTH-1] == CH_V);
      if (tag_vld_q[TAG_DEPTH-1]) begin
        dout_o <= mem_rdata_i;
      end

      mem_rd_o <= 1'b0;
      done_o   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_q[CH_COL] <= base0_i;
            rem_q[CH_COL]  <= len0_i;
            addr_q[CH_V]   <= base1_i;
            rem_q[CH_V]    <= len1_i;
            busy_o         <= 1'b1;
            if ((len0_i == '0) && (len1_i == '0)) begin
              state_q <= DONE;
              done_o  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end

        RUN: begin
          if (issue) begin
            mem_addr_o <= gnt_ch ? addr_q[CH_V] : addr_q[CH_COL];
            mem_rd_o   <= 1'b1;
            rr_q       <= gnt_ch;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            if (last_issue) begin
              state_q <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (tag_vld_q == '0) begin
            state_q <= DONE;
            done_o  <= 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
